cla_adder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single 64-bit carry-lookahead adder (`carry_look_ahead_adder`) among `N_REQ` requesters. It accepts one add request at a time over a valid/ready handshake and registers the operands. It then captures the adder result and returns it on a single response channel tagged with the requester ID. It sits between the ALU-side request ports and the shared adder datapath.

---
 rtl/cla_adder_arbiter_if.sv | 28 ++
 rtl/cla_adder_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cla_adder_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_adder_arbiter_if.sv
// Request/response bundle between the ALU-side requesters and cla_adder_arbiter.
// master = requesters + response consumer, slave = arbiter.
interface cla_adder_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*64-1:0] req_a;
    logic [N_REQ*64-1:0] req_b;
    logic [N_REQ-1:0]    req_cin;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [63:0]         resp_sum;
    logic                resp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_cout
    );
endinterface

// File: rtl/cla_adder_arbiter.sv
// Round-robin sequencer sharing one 64-bit carry-lookahead adder among N_REQ requesters.
// One transaction in flight at a time: accept -> calc -> respond.

module carry_look_ahead_adder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;
    logic [15:0] gg;
    logic [15:0] gp;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit lookahead groups; group generate/propagate feed the next group's carry
    always_comb begin
        c    = '0;
        gg   = '0;
        gp   = '0;
        c[0] = cin;
        for (int k = 0; k < 16; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
        end
    end

    assign sum  = p ^ c[63:0];
    assign cout = c[64];
endmodule

// state | meaning
// IDLE  | grant offered to first valid requester at/after rr_ptr
// CALC  | operand registers drive the adder, result captured at cycle end
// RESP  | response held on resp_* until resp_ready
module cla_adder_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_adder_arbiter_if.slave   bus,
    output logic                 busy
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_reg;
    logic [63:0]     op_a;
    logic [63:0]     op_b;
    logic            op_cin;

    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic [63:0]     sel_a;
    logic [63:0]     sel_b;
    logic            sel_cin;
    logic [63:0]     sum;
    logic            cout;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % N_REQ);
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && !rst && grant_vld)
            bus.req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a   = bus.req_a[i*64 +: 64];
                sel_b   = bus.req_b[i*64 +: 64];
                sel_cin = bus.req_cin[i];
            end
        end
    end

    carry_look_ahead_adder u_cla (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            id_reg         <= '0;
            op_a           <= '0;
            op_b           <= '0;
            op_cin         <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_sum   <= '0;
            bus.resp_cout  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_cin <= sel_cin;
                        id_reg <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    bus.resp_sum   <= sum;
                    bus.resp_cout  <= cout;
                    bus.resp_id    <= id_reg;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Scoreboard bench for cla_adder_arbiter: directed scenarios followed by random traffic,
// checked against a cycle-level model of grant order, arithmetic and response timing.
module tb_cla_adder_arbiter;
    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_adder_arbiter_if #(.N_REQ(N)) bus ();

    cla_adder_arbiter #(.N_REQ(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    typedef struct {
        int          id;
        logic [63:0] sum;
        logic        cout;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          m_ptr;
    bit          in_flight;
    bit          prev_v;
    logic [63:0] h_sum;
    logic        h_cout;
    logic [63:0] h_id;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] last_acc;
    logic [N-1:0] auto_mode;
    int          gl_id[$];
    int          gl_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return 64'(0);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic cin);
        bus.req_a[i*64 +: 64] = a;
        bus.req_b[i*64 +: 64] = b;
        bus.req_cin[i]        = cin;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic load_rand(input int i);
        set_req(i, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
    endtask

    // Reference: grant = first valid scanning up from the model pointer; result = a+b+cin in 65 bits
    task automatic mon_step();
        logic [IDW-1:0] j;
        logic [64:0]    full;
        exp_t           e;
        exp_rdy = '0;
        if (!rst && !in_flight) begin
            for (int k = 0; k < N; k++) begin
                j = IDW'((m_ptr + k) % N);
                if (exp_rdy == '0 && bus.req_valid[j]) exp_rdy[j] = 1'b1;
            end
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(in_flight));

        if (bus.resp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got id %0d sum %0h, expected no response", bus.resp_id, bus.resp_sum);
            end else begin
                e = sb.pop_front();
                check("resp_id", 64'(bus.resp_id), 64'(e.id));
                check("resp_sum", bus.resp_sum, e.sum);
                check("resp_cout", 64'(bus.resp_cout), 64'(e.cout));
                check("resp_latency", 64'(cyc), 64'(e.due));
            end
            h_sum  = bus.resp_sum;
            h_cout = bus.resp_cout;
            h_id   = 64'(bus.resp_id);
        end else if (bus.resp_valid) begin
            check("hold_sum", bus.resp_sum, h_sum);
            check("hold_cout", 64'(bus.resp_cout), 64'(h_cout));
            check("hold_id", 64'(bus.resp_id), h_id);
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            tests++;
            fails++;
            $display("FAIL resp_missing: got no resp_valid, expected response id %0d by cycle %0d", sb[0].id, sb[0].due);
            void'(sb.pop_front());
        end
        prev_v = bus.resp_valid;

        if (rst) begin
            in_flight = 1'b0;
            m_ptr     = 0;
            sb.delete();
        end else if (exp_rdy != '0) begin
            for (int k = 0; k < N; k++) begin
                if (exp_rdy[k]) begin
                    full = {1'b0, bus.req_a[k*64 +: 64]} + {1'b0, bus.req_b[k*64 +: 64]}
                         + 65'(bus.req_cin[k]);
                    sb.push_back('{k, full[63:0], full[64], cyc + 2});
                    m_ptr = (k + 1) % N;
                end
            end
            in_flight = 1'b1;
        end else if (in_flight && bus.resp_valid && bus.resp_ready) begin
            in_flight = 1'b0;
        end
    endtask

    // One clock: note accepts at the edge, then refresh or retire accepted requesters
    task automatic tick();
        @(negedge clk);
        last_acc = rst ? '0 : (bus.req_valid & bus.req_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_acc[i]) begin
                gl_id.push_back(i);
                gl_cyc.push_back(cyc);
                if (auto_mode[i]) load_rand(i);
                else bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_accept(input int i);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc[i] && n < 30);
        tests++;
        if (!last_acc[i]) begin
            fails++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected requester %0d accepted", n, i);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus.req_valid != '0) && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL drain_timeout: got busy=%0b valid=%0h, expected idle", busy, bus.req_valid);
        end
    endtask

    initial begin
        logic [63:0] s_sum;
        logic [63:0] s_id;
        int          n;

        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_cin    = '0;
        bus.resp_ready = 1'b1;
        auto_mode      = '0;
        last_acc       = '0;
        in_flight      = 1'b0;
        m_ptr          = 0;
        prev_v         = 1'b0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Carry wrap, operands presented during reset and must not be taken early
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        repeat (3) tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'h0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("rst_resp_id", 64'(bus.resp_id), 64'h0);
        check("rst_resp_sum", bus.resp_sum, 64'h0);
        check("rst_resp_cout", 64'(bus.resp_cout), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        #1;
        check("first_idle_grant", 64'(bus.req_ready), 64'h1);
        wait_accept(0);
        wait_idle();

        // Carry-in from requester 2 with pointer at 1
        set_req(2, 64'h1234, 64'h0FFF, 1'b1);
        wait_accept(2);
        check("rr_ptr_after_2", 64'(dut.rr_ptr), 64'h3);
        wait_idle();

        // Round-robin with every requester continuously valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gl_id.delete();
        gl_cyc.delete();
        auto_mode = '1;
        for (int i = 0; i < N; i++) load_rand(i);
        repeat (24) tick();
        check("rr_count", 64'(gl_id.size() >= 8), 64'h1);
        for (int k = 0; k < 8 && k < gl_id.size(); k++) begin
            check("rr_order", 64'(gl_id[k]), 64'(k % N));
            if (k > 0) check("rr_spacing", 64'(gl_cyc[k] - gl_cyc[k-1]), 64'h3);
        end
        auto_mode = '0;
        wait_idle();

        // Backpressure with requester 1 waiting behind a stalled response
        bus.resp_ready = 1'b0;
        auto_mode[1]   = 1'b1;
        load_rand(1);
        wait_accept(1);
        auto_mode[1] = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 6) begin
            tick();
            n++;
        end
        check("bp_resp_valid", 64'(bus.resp_valid), 64'h1);
        s_sum = bus.resp_sum;
        s_id  = 64'(bus.resp_id);
        repeat (5) begin
            tick();
            check("bp_req_ready", 64'(bus.req_ready), 64'h0);
            check("bp_busy", 64'(busy), 64'h1);
            check("bp_sum_stable", bus.resp_sum, s_sum);
            check("bp_id_stable", 64'(bus.resp_id), s_id);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        #1;
        check("bp_regrant", 64'(bus.req_ready), 64'h2);
        bus.resp_ready = 1'b1;
        wait_accept(1);
        wait_idle();

        // Reset while in CALC discards the operation
        load_rand(0);
        wait_accept(0);
        check("calc_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_rr_ptr", 64'(dut.rr_ptr), 64'h0);
        repeat (6) tick();

        // Requester 3 withdraws before the edge while pointer favours it
        load_rand(1);
        wait_accept(1);
        wait_idle();
        load_rand(1);
        load_rand(3);
        #1;
        check("drop_pre_grant", 64'(bus.req_ready), 64'h8);
        bus.req_valid[3] = 1'b0;
        #1;
        check("drop_post_grant", 64'(bus.req_ready), 64'h2);
        tick();
        check("drop_accept", 64'(last_acc), 64'h2);
        wait_idle();

        // Random traffic with random response backpressure
        for (int c = 0; c < 400; c++) begin
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 5) == 0) load_rand(i);
            auto_mode = N'($urandom);
            tick();
        end
        bus.resp_ready = 1'b1;
        auto_mode      = '0;
        wait_idle();
        repeat (4) tick();
        check("sb_empty", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
